led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern sequencer: drives a W-bit LED bank with dot-shift, fill and bounce
//  patterns, advancing one step per prescaled tick. It is the generalised successor of the fixed
//  8-bit shift/fill LED blocks.
//  It adds runtime mode select, one-shot vs repeat, a DONE flag and an internal clock divider.
//  It sits between the board clock and the LED pins; SS is the run/pause switch.
// PARAMETERS
//  W    8   LED count, >= 2
//  DIV  1   clk cycles per pattern step, >= 1 (1 = step every clk)
// PORTS
//  clk     in   1    system clock, rising edge
//  reset   in   1    asynchronous, active-high reset
//  SS      in   1    1 = run, 0 = pause (all state frozen)
//  MODE    in   3    0 DOT_R, 1 DOT_L, 2 FILL_R, 3 FILL_L, 4 BOUNCE, 5-7 reserved
//  REPEAT  in   1    1 = loop pattern; 0 = one-shot, then stop with DONE=1
//  LED     out  W    registered LED drive, bit W-1 = leftmost
//  DONE    out  1    registered; 1 = one-shot sequence finished
//  STEP    out  1    registered 1-clk pulse coinciding with every LED update
// BEHAVIOUR
//  - Reset (async): LED=0, DONE=0, STEP=0, phase k=0, dir=fwd, prescaler=0, mode_q=MODE.
//  - Prescaler counts 0..DIV-1 only while SS=1 and DONE=0. tick = (cnt==DIV-1 && SS). SS=0 holds cnt.
//  - Phase k in 0..W, where k=0 is blank. Pattern(k), for k>=1:
//      DOT_R: only bit W-k set.    DOT_L: only bit k-1 set.
//      FILL_R: top k bits set.     FILL_L: low k bits set.    All modes: k=0 -> all zero.
//  - On tick (DOT/FILL): if k<W then k<=k+1. If k==W then k<=0, and if REPEAT=0 also DONE<=1.
//    In the same clk: LED<=pattern(next k), STEP<=1.
//  - Example, W=8, DOT_R, REPEAT=1: 00,80,40,20,10,08,04,02,01,00,80,...
//    FILL_R: 00,80,C0,...,FF,00,...
//  - BOUNCE: k climbs 1..W then falls W-1..1, reversing dir at k==W and at k==1.
//    k never returns to 0. The dot ping-pongs with period 2W-2. REPEAT is ignored and DONE stays 0.
//  - DONE=1: no ticks; LED holds 0. DONE clears only on reset or a MODE change.
//    Toggling REPEAT alone does not restart.
//  - MODE change (MODE != mode_q, sampled every clk, regardless of SS): next clk gives k=0,
//    LED=0, dir=fwd, cnt=0, DONE=0, STEP=0, mode_q<=MODE. A mode change outranks a tick in the same clk.
//  - Reserved MODE 5-7: LED=0, k held at 0, no STEP, DONE=0.
//  - Latency: LED changes in the clk edge where tick is true. The first lit pattern appears DIV clks
//    after SS rises from reset.
//  - REPEAT changing mid-sequence takes effect at the next k==W wrap.
//  - Widths: k and the prescaler use $clog2(W+1) and $clog2(DIV) bits (min 1). There is no overflow
//    past W or DIV-1.
// STRUCTURE
//  - Shared package led_pkg: MODE encodings (MODE_DOT_R..MODE_BOUNCE) and localparam MODE_W=3.
//  - Sub-module led_tick_div #(DIV): prescaler with en=SS&~DONE and clr=mode change; outputs tick.
//  - Top: phase/dir register, mode_q change detect, combinational pattern(k,mode) function,
//    and LED/DONE/STEP output registers.
// TESTING  (W=8 unless noted)
//  1. DIV=1, MODE=0, REPEAT=1, SS=1 for 20 clks -> LED 00,80,40,..,01,00,80,...; STEP high every clk.
//  2. DIV=3, MODE=3, REPEAT=0 -> LED 01,03,..,FF each 3 clks apart, then 00 with DONE=1.
//     Further clks hold 00 and STEP stays 0.
//  3. MODE=4, 30 ticks -> 01,02,..,80,40,..,01,02,...; DONE never asserts; reversal seen at 80 and 01.
//  4. MODE=2 at LED=E0: drop SS for 10 clks -> LED, STEP, cnt frozen. Raise SS -> continues F0.
//  5. Change MODE 0->1 in the same clk as a tick -> next LED=00 with k=0, then 01.
//     DONE cleared if previously set. MODE=6 -> LED stays 00.
//  6. Assert reset mid-sequence between clk edges -> LED=00 and DONE=0 immediately.
//     Release -> sequence restarts from k=0.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pkg
// Brief  : Shared MODE encodings and bounce direction type for led_pattern_gen.
// Rev    : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_DOT_R  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_DOT_L  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_FILL_R = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FILL_L = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd4;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_div.sv
`default_nettype none
// ============================================================================
// Module : led_tick_div
// Brief  : Prescaler producing a one-clk tick every DIV enabled clocks.
// Rev    : 1.0  initial release
// ============================================================================
module led_tick_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule : led_tick_div
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_gen
// Brief  : W-bit LED sequencer (dot, fill, bounce) stepping on prescaled ticks.
// Rev    : 1.0  initial release
// ============================================================================
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SS,
    input  logic [MODE_W-1:0] MODE,
    input  logic              REPEAT,
    output logic [W-1:0]      LED,
    output logic              DONE,
    output logic              STEP
);

    localparam int KW = $clog2(W + 1);
    localparam logic [KW-1:0] K_MAX = KW'(W);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    logic [KW-1:0]     k_q, k_d;
    dir_e              dir_q, dir_d;
    logic [W-1:0]      led_q, led_d;
    logic              done_q, done_d;
    logic              step_q, step_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    logic w_mode_chg;
    logic w_div_en;
    logic w_tick;

    function automatic logic [W-1:0] pattern(input logic [KW-1:0] k,
                                             input logic [MODE_W-1:0] mode);
        logic [W-1:0] p;
        int kk;
        p  = '0;
        kk = int'(k);
        for (int i = 0; i < W; i++) begin
            if (kk != 0) begin
                case (mode)
                    MODE_DOT_R:              p[i] = (i == W - kk);
                    MODE_DOT_L, MODE_BOUNCE: p[i] = (i == kk - 1);
                    MODE_FILL_R:             p[i] = (i >= W - kk);
                    MODE_FILL_L:             p[i] = (i < kk);
                    default:                 p[i] = 1'b0;
                endcase
            end
        end
        return p;
    endfunction

    assign w_mode_chg = (MODE != mode_q);
    assign w_div_en   = SS & ~done_q;

    led_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (reset),
        .en   (w_div_en),
        .clr  (w_mode_chg),
        .tick (w_tick)
    );

    always_comb begin
        k_d    = k_q;
        dir_d  = dir_q;
        led_d  = led_q;
        done_d = done_q;
        step_d = 1'b0;
        mode_d = mode_q;
        if (w_mode_chg) begin
            // A mode change restarts the sequence and wins over a coincident tick.
            k_d    = '0;
            dir_d  = DIR_FWD;
            led_d  = '0;
            done_d = 1'b0;
            mode_d = MODE;
        end else if (mode_q > MODE_BOUNCE) begin
            k_d    = '0;
            led_d  = '0;
            done_d = 1'b0;
        end else if (w_tick) begin
            step_d = 1'b1;
            if (mode_q == MODE_BOUNCE) begin
                if (dir_q == DIR_FWD) begin
                    if (k_q == K_MAX) begin
                        k_d   = k_q - K_ONE;
                        dir_d = DIR_BWD;
                    end else begin
                        k_d = k_q + K_ONE;
                    end
                end else begin
                    if (k_q == K_ONE) begin
                        k_d   = k_q + K_ONE;
                        dir_d = DIR_FWD;
                    end else begin
                        k_d = k_q - K_ONE;
                    end
                end
            end else if (k_q == K_MAX) begin
                k_d = '0;
                if (!REPEAT) begin
                    done_d = 1'b1;
                end
            end else begin
                k_d = k_q + K_ONE;
            end
            led_d = pattern(k_d, mode_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q    <= '0;
            dir_q  <= DIR_FWD;
            led_q  <= '0;
            done_q <= 1'b0;
            step_q <= 1'b0;
            mode_q <= MODE;
        end else begin
            k_q    <= k_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            done_q <= done_d;
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    assign LED  = led_q;
    assign DONE = done_q;
    assign STEP = step_q;

endmodule : led_pattern_gen
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_led_pattern_gen
// Brief  : Bench for led_pattern_gen, two instances (DIV=1 and DIV=3), W=8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic       SS;
    logic [2:0] MODE;
    logic       REPEAT;
    logic [W-1:0] led1, led3;
    logic       done1, done3, step1, step3;

    int nchecks = 0;
    int npass   = 0;

    // Reference state: ticks since last restart, prescaler phase, latched mode.
    int divs [2] = '{1, 3};
    int mq   [2];
    int n    [2];
    int pc   [2];
    int done [2];
    int estp [2];

    led_pattern_gen #(.W(W), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .SS(SS), .MODE(MODE), .REPEAT(REPEAT),
        .LED(led1), .DONE(done1), .STEP(step1)
    );

    led_pattern_gen #(.W(W), .DIV(3)) u_dut3 (
        .clk(clk), .reset(reset), .SS(SS), .MODE(MODE), .REPEAT(REPEAT),
        .LED(led3), .DONE(done3), .STEP(step3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input int mode, input int k);
        int v;
        if (k == 0 || mode > 4) return '0;
        case (mode)
            0:       v = 1 << (W - k);
            1, 4:    v = 1 << (k - 1);
            2:       v = ((1 << k) - 1) << (W - k);
            default: v = (1 << k) - 1;
        endcase
        return W'(v);
    endfunction

    // Phase reached after t ticks: dot/fill cycle through W+1 phases, bounce ping-pongs.
    function automatic int kof(input int mode, input int t);
        int m;
        if (mode == 4) begin
            if (t == 0) return 0;
            m = (t - 1) % (2 * W - 2);
            return (m < W) ? m + 1 : 2 * W - 1 - m;
        end
        return t % (W + 1);
    endfunction

    function automatic logic [W-1:0] exp_led(input int d);
        if (done[d] != 0) return '0;
        return pat(mq[d], kof(mq[d], n[d]));
    endfunction

    task automatic model_reset(input int d);
        mq[d]   = int'(MODE);
        n[d]    = 0;
        pc[d]   = 0;
        done[d] = 0;
        estp[d] = 0;
    endtask

    task automatic model_edge(input int d);
        bit en, tk;
        if (reset) begin
            model_reset(d);
        end else if (int'(MODE) != mq[d]) begin
            mq[d]   = int'(MODE);
            n[d]    = 0;
            pc[d]   = 0;
            done[d] = 0;
            estp[d] = 0;
        end else begin
            en = SS && (done[d] == 0);
            tk = en && (pc[d] == divs[d] - 1);
            if (en) pc[d] = (pc[d] + 1) % divs[d];
            if (mq[d] > 4) begin
                n[d]    = 0;
                estp[d] = 0;
            end else begin
                estp[d] = tk ? 1 : 0;
                if (tk) begin
                    n[d]++;
                    if (mq[d] != 4 && (n[d] % (W + 1)) == 0 && !REPEAT) done[d] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("led_div1",  32'(led1),  32'(exp_led(0)));
        chk("done_div1", 32'(done1), 32'(done[0]));
        chk("step_div1", 32'(step1), 32'(estp[0]));
        chk("led_div3",  32'(led3),  32'(exp_led(1)));
        chk("done_div3", 32'(done3), 32'(done[1]));
        chk("step_div3", 32'(step3), 32'(estp[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        SS     = 1'b0;
        MODE   = 3'd0;
        REPEAT = 1'b1;
        #2;
        model_reset(0);
        model_reset(1);
        check_all();
        repeat (2) cyc();
        reset = 1'b0;
        SS    = 1'b1;

        // Dot right, repeating.
        repeat (20) cyc();
        chk("t1_step_every_clk", 32'(step1), 32'd1);

        // Fill left, one-shot; ends blank with DONE.
        MODE   = 3'd3;
        REPEAT = 1'b0;
        repeat (40) cyc();
        chk("t2_done3", 32'(done3), 32'd1);
        chk("t2_led3_blank", 32'(led3), 32'd0);

        // Bounce: DONE clears on mode change and never sets.
        MODE = 3'd4;
        repeat (90) cyc();

        // Fill right, pause at E0.
        MODE   = 3'd2;
        REPEAT = 1'b1;
        guard  = 0;
        do begin
            cyc();
            guard++;
        end while (led3 !== 8'hE0 && guard < 60);
        chk("t4_reach_e0", 32'(led3), 32'hE0);
        SS = 1'b0;
        repeat (10) cyc();
        chk("t4_frozen", 32'(led3), 32'hE0);
        SS = 1'b1;
        repeat (6) cyc();

        // Dot right one-shot to DONE, then mode change clears it; mode change on a tick.
        MODE   = 3'd0;
        REPEAT = 1'b0;
        repeat (30) cyc();
        MODE   = 3'd1;
        REPEAT = 1'b1;
        cyc();
        chk("t5_done_cleared", 32'(done3), 32'd0);
        MODE = 3'd0;
        repeat (4) cyc();
        guard = 0;
        while (pc[1] != 2 && guard < 5) begin
            cyc();
            guard++;
        end
        MODE = 3'd1;
        cyc();
        chk("t5_chg_led_blank", 32'(led3), 32'd0);
        repeat (3) cyc();
        chk("t5_then_01", 32'(led3), 32'h01);
        MODE = 3'd6;
        repeat (10) cyc();

        // Asynchronous reset between edges.
        MODE = 3'd2;
        repeat (7) cyc();
        #2;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        chk("t6_async_led", 32'(led3), 32'd0);
        chk("t6_async_done", 32'(done3), 32'd0);
        check_all();
        repeat (2) cyc();
        reset = 1'b0;
        repeat (12) cyc();

        // Randomised run.
        repeat (500) begin
            if ($urandom_range(0, 39) == 0) MODE = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) REPEAT = ~REPEAT;
            SS = ($urandom_range(0, 9) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule : tb_led_pattern_gen
`default_nettype wire
